idelay_tap_loader: RTL
======================

// Module: idelay_tap_loader
// PURPOSE
//  Upstream sequencer for io_delay_module. Takes a tap-load request from the MicroBlaze
//  GPIO (gpio02_1_o domain) and drives the ldcnt_0x/dicnt_0x strobes one channel at a time.
//  Reads back docnt_0x, retries on mismatch, and returns busy/done/error status to the GPIO
//  read-back bits. Runs on clk_io_ref, the 200 MHz IDELAY reference clock.
// PARAMETERS
//  NCH        4     number of delay channels (ldcnt/dicnt/docnt sets)
//  TAP_W      5     tap count width per channel
//  SETTLE_CYC 4     cycles waited after a load strobe before read-back (>=1)
//  MAX_RETRY  3     extra load attempts per channel before flagging an error
//  SWEEP_DIV  1024  sweep step period in clk cycles (IDELAY_TAP_SWEEP_EN only)
// PORTS
//  clk      in   1          200 MHz clk_io_ref
//  rst      in   1          reset, asynchronous, active-high
//  rdy      in   1          IDELAYCTRL ready from io_delay_module
//  cmd_req  in   1          request level from GPIO; each toggle = one new request (async)
//  cmd_mask in   NCH        channel enable, sampled on the request edge
//  cmd_tap  in   NCH*TAP_W  target taps, ch0 in [TAP_W-1:0], sampled on the request edge
//  ldcnt    out  NCH        one-cycle load strobe per channel
//  dicnt    out  NCH*TAP_W  tap value presented to each channel
//  docnt    in   NCH*TAP_W  current tap read back from each channel
//  tap_cur  out  NCH*TAP_W  last verified tap per channel
//  busy     out  1          sequence in progress
//  done     out  1          one-cycle pulse at end of sequence
//  err_ch   out  NCH        channel failed after MAX_RETRY; cleared on next accepted request
//  ovr      out  1          sticky: request toggled while busy; cleared on next accepted request
// BEHAVIOUR
//  - Reset: all outputs are 0 asynchronously; FSM=IDLE; retry=0; ldcnt drops immediately.
//  - Request input: cmd_req passes through a 2-FF synchronizer and then an edge detector
//    (either edge). The request is seen 3 clk after cmd_req changes. Software holds
//    cmd_mask/cmd_tap stable from before the toggle until done.
//  - In IDLE, an edge captures cmd_mask/cmd_tap into tgt regs and clears err_ch and ovr.
//    It also sets ch=0, and the FSM goes to WAIT_RDY.
//  - An edge seen while busy is ignored and sets ovr.
//  - FSM states and transitions:
//    IDLE -> WAIT_RDY on a request edge.
//    WAIT_RDY -> SCAN when rdy=1.
//    SCAN: skip channels whose mask bit is 0 (no cycles spent on them).
//      Enabled channel -> LOAD; no enabled channel left -> DONE.
//    LOAD: ldcnt[ch]=1 for exactly 1 cycle -> SETTLE.
//    SETTLE: count SETTLE_CYC cycles -> CHECK.
//    CHECK: if docnt[ch]==tgt[ch], set tap_cur[ch]=tgt[ch], retry=0, ch++ -> SCAN.
//      On mismatch with retry<MAX_RETRY: retry++ -> LOAD.
//      On mismatch with retry==MAX_RETRY: err_ch[ch]=1, retry=0, ch++ -> SCAN.
//    DONE: done=1 for one cycle -> IDLE.
//  - dicnt[ch] is driven from tgt[ch] continuously from capture onward; unloaded channels
//    hold their previous value. ldcnt is never high on more than one bit at a time.
//  - Latency: a channel that matches first time takes SETTLE_CYC+2 cycles (LOAD+SETTLE+CHECK).
//    An all-zero mask gives done 2 cycles after WAIT_RDY exits; busy is high for 3 cycles.
//  - busy=1 in every state except IDLE, including the DONE cycle.
//  - If rdy falls during LOAD/SETTLE/CHECK, go to WAIT_RDY. The same channel restarts at LOAD
//    when rdy returns, and retry is not incremented.
//  - ch and retry counters saturate/wrap safely; ch never indexes past NCH-1.
// CONFIGURATION
//  - IDELAY_TAP_SWEEP_EN defined: adds port sweep_en (in, 1).
//    When sweep_en=1 and the FSM is IDLE, a SWEEP_DIV counter runs. Each time it expires,
//    tgt[ch]+1 (mod 2^TAP_W, 31->0) is applied to every channel in the last captured mask,
//    and a normal sequence runs.
//    A request edge takes priority over a sweep tick in the same cycle.
//    sweep_en=0 clears the counter.
//  - Not defined: no sweep_en port and no sweep counter; loads happen only on request edges.
// TESTING
//  1 Reset: assert rst mid-SETTLE -> ldcnt/busy/done/err_ch/ovr/tap_cur=0 same cycle,
//    FSM back in IDLE.
//  2 Toggle cmd_req with mask=4'b1111, taps={31,16,1,0}, model echoes dicnt on ldcnt ->
//    four single ldcnt pulses in order 0..3, SETTLE_CYC+2 apart.
//    Then done, tap_cur={31,16,1,0}, err_ch=0.
//  3 Model pins ch2 docnt=7 while target is 9 -> 4 ldcnt[2] pulses, then err_ch=4'b0100.
//    ch3 still loads, and done pulses.
//  4 Toggle cmd_req again while busy -> ovr=1 and the sequence is unaffected.
//    The next accepted toggle clears ovr.
//  5 Drop rdy for 10 cycles during ch1 SETTLE -> no ldcnt while rdy=0.
//    ch1 reloads once after rdy=1, and err_ch=0.
//  6 (IDELAY_TAP_SWEEP_EN) sweep_en=1, SWEEP_DIV=8, mask=0001, tap=30 -> tap_cur[0] steps
//    31, 0, 1 on successive sweeps.

Source files
------------

// File: rtl/idelay_tap_loader.sv
// idelay_tap_loader: loads IDELAY taps one channel at a time, verifies them via docnt and retries on mismatch; IDELAY_TAP_SWEEP_EN adds a periodic +1 tap sweep.
// Latency: a request is acted on 3 clk after cmd_req toggles; every load attempt costs SETTLE_CYC+2 clk.
// Backpressure: waits in WAIT_RDY while rdy=0; a request arriving while busy is dropped and raises ovr.
module idelay_tap_loader #(
    parameter int NCH        = 4,
    parameter int TAP_W      = 5,
    parameter int SETTLE_CYC = 4,
    parameter int MAX_RETRY  = 3
`ifdef IDELAY_TAP_SWEEP_EN
   ,parameter int SWEEP_DIV  = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 cmd_req,
    input  logic [NCH-1:0]       cmd_mask,
    input  logic [NCH*TAP_W-1:0] cmd_tap,
    output logic [NCH-1:0]       ldcnt,
    output logic [NCH*TAP_W-1:0] dicnt,
    input  logic [NCH*TAP_W-1:0] docnt,
    output logic [NCH*TAP_W-1:0] tap_cur,
    output logic                 busy,
    output logic                 done,
    output logic [NCH-1:0]       err_ch,
    output logic                 ovr
`ifdef IDELAY_TAP_SWEEP_EN
   ,input  logic                 sweep_en
`endif
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_SCAN, S_LOAD, S_SETTLE, S_CHECK, S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [NCH-1:0][TAP_W-1:0] tgt_tap, cur_tap, docnt_a;
    logic [NCH-1:0]            tgt_mask;
    logic [CH_W-1:0]           ch, scan_ch, nxt_ch;
    logic                      scan_hit, nxt_hit;
    logic [RT_W-1:0]           retry;
    logic [ST_W-1:0]           settle_cnt;
    logic [2:0]                req_sync;
    logic                      req_edge, sweep_tick, start;
    logic                      settle_last, chk_pass, retry_max, ch_finish;

    assign docnt_a     = docnt;
    assign dicnt       = tgt_tap;
    assign tap_cur     = cur_tap;
    assign req_edge    = req_sync[2] ^ req_sync[1];
    assign start       = (state == S_IDLE) && (req_edge || sweep_tick);
    assign settle_last = (settle_cnt == ST_W'(SETTLE_CYC - 1));
    assign chk_pass    = (docnt_a[ch] == tgt_tap[ch]);
    assign retry_max   = (retry == RT_W'(MAX_RETRY));
    assign ch_finish   = chk_pass || retry_max;

`ifdef IDELAY_TAP_SWEEP_EN
    localparam int SW_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    logic [SW_W-1:0] sweep_cnt;

    assign sweep_tick = sweep_en && (state == S_IDLE) && (sweep_cnt == SW_W'(SWEEP_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt <= '0;
        end else if (!sweep_en || sweep_tick) begin
            sweep_cnt <= '0;
        end else if (state == S_IDLE) begin
            sweep_cnt <= sweep_cnt + SW_W'(1);
        end
    end
`else
    assign sweep_tick = 1'b0;
`endif

    // Lowest enabled channel at/after ch (scan) and strictly after ch (look-ahead from CHECK).
    always_comb begin
        scan_hit = 1'b0;
        scan_ch  = '0;
        nxt_hit  = 1'b0;
        nxt_ch   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (tgt_mask[i] && (i >= int'(ch))) begin
                scan_hit = 1'b1;
                scan_ch  = CH_W'(i);
            end
            if (tgt_mask[i] && (i > int'(ch))) begin
                nxt_hit = 1'b1;
                nxt_ch  = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_WAIT_RDY;
            S_WAIT_RDY: if (rdy) state_nxt = S_SCAN;
            S_SCAN:     state_nxt = scan_hit ? S_LOAD : S_DONE;
            S_LOAD:     state_nxt = !rdy ? S_WAIT_RDY : S_SETTLE;
            S_SETTLE:   state_nxt = !rdy ? S_WAIT_RDY : (settle_last ? S_CHECK : S_SETTLE);
            S_CHECK: begin
                if (!rdy)           state_nxt = S_WAIT_RDY;
                else if (!ch_finish) state_nxt = S_LOAD;
                else                state_nxt = nxt_hit ? S_LOAD : S_DONE;
            end
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ldcnt = '0;
        if ((state == S_LOAD) && rdy) ldcnt[ch] = 1'b1;
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync   <= '0;
            tgt_mask   <= '0;
            tgt_tap    <= '0;
            cur_tap    <= '0;
            err_ch     <= '0;
            ovr        <= 1'b0;
            ch         <= '0;
            retry      <= '0;
            settle_cnt <= '0;
        end else begin
            req_sync <= {req_sync[1:0], cmd_req};
            if ((state == S_IDLE) && req_edge) begin
                tgt_mask <= cmd_mask;
                tgt_tap  <= cmd_tap;
                err_ch   <= '0;
                ovr      <= 1'b0;
                ch       <= '0;
                retry    <= '0;
            end else if (start) begin
                // Sweep step: every channel of the last captured mask advances one tap, wrapping.
                for (int i = 0; i < NCH; i++) begin
                    if (tgt_mask[i]) tgt_tap[i] <= tgt_tap[i] + TAP_W'(1);
                end
                ch    <= '0;
                retry <= '0;
            end
            if ((state != S_IDLE) && req_edge) ovr <= 1'b1;
            case (state)
                S_SCAN:   if (scan_hit) ch <= scan_ch;
                S_LOAD:   settle_cnt <= '0;
                S_SETTLE: settle_cnt <= settle_cnt + ST_W'(1);
                S_CHECK: begin
                    if (rdy) begin
                        if (chk_pass)       cur_tap[ch] <= tgt_tap[ch];
                        else if (retry_max) err_ch[ch]  <= 1'b1;
                        if (ch_finish) begin
                            retry <= '0;
                            if (nxt_hit) ch <= nxt_ch;
                        end else begin
                            retry <= retry + RT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
